dac_ctrl: RTL and testbench

- Serial write controller for a 12-bit SPI-style DAC with a 16-bit frame (DAC121S101-class). It is the transmit counterpart of the ADC read controller on the same board.
- It accepts a 12-bit code and a 2-bit power-down field from the acquisition state machine. It then drives SYNC, SCLK and DIN to shift out one 16-bit frame, MSB first.
- The DAC samples DIN on the falling edge of SCLK.

---
 rtl/dac_ctrl_if.sv | 22 ++
 rtl/dac_ctrl.sv | 131 +++++++++++++
 tb/tb_dac_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_ctrl_if.sv
// Request/status and serial-pin bundle between the acquisition FSM, dac_ctrl and the DAC.
interface dac_ctrl_if;
    logic        ctrl;
    logic [11:0] data;
    logic [1:0]  pd;
    logic        ready;
    logic        busy;
    logic        done;
    logic        sync;
    logic        sclk;
    logic        din;

    modport master (
        output ctrl, data, pd,
        input  ready, busy, done, sync, sclk, din
    );

    modport slave (
        input  ctrl, data, pd,
        output ready, busy, done, sync, sclk, din
    );
endinterface

// File: rtl/dac_ctrl.sv
// Serial write controller for a 12-bit DAC with a 16-bit frame.
// The frame is shifted out MSB first, and the DAC samples din on the falling edge of sclk.
module dac_ctrl #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    dac_ctrl_if.slave  bus
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYC) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [14:0]        rem_q, rem_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sync_q, sync_d;
    logic               sclk_q, sclk_d;
    logic               din_q, din_d;
    logic [15:0]        frame_c;

    // State, counters and every output are registered here.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            rem_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sync_q  <= sync_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        rem_d   = rem_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sync_d  = sync_q;
        sclk_d  = sclk_q;
        din_d   = din_q;
        frame_c = {2'b00, bus.pd, bus.data};

        case (state_q)
            IDLE: begin
                if (bus.ctrl) begin
                    state_d = SHIFT;
                    rem_d   = frame_c[14:0];
                    din_d   = frame_c[15];
                    sync_d  = 1'b0;
                    sclk_d  = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = 4'd15;
                end
            end
            SHIFT: begin
                // Each half-period lasts CLK_DIV cycles; din advances only as sclk rises.
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == 4'd0) begin
                        state_d = HOLD;
                        sync_d  = 1'b1;
                        sclk_d  = 1'b1;
                        din_d   = 1'b0;
                        done_d  = 1'b1;
                        gap_d   = '0;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        sclk_d = 1'b1;
                        din_d  = rem_q[14];
                        rem_d  = {rem_q[13:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sync  = sync_q;
    assign bus.sclk  = sclk_q;
    assign bus.din   = din_q;
endmodule

// File: tb/tb_dac_ctrl.sv
// Bench for dac_ctrl: a default-divider and a fast-divider instance share one stimulus and one frame monitor.
module tb_dac_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        t_ctrl;
    logic [11:0] t_data;
    logic [1:0]  t_pd;

    always #5 clk_in = ~clk_in;

    dac_ctrl_if d_if ();
    dac_ctrl_if f_if ();

    assign d_if.ctrl = t_ctrl & ~sel;
    assign f_if.ctrl = t_ctrl & sel;
    assign d_if.data = t_data;
    assign f_if.data = t_data;
    assign d_if.pd   = t_pd;
    assign f_if.pd   = t_pd;

    dac_ctrl #(.CLK_DIV(2), .GAP_CYC(4)) u_def (.clk_in(clk_in), .rst_n(rst_n), .bus(d_if));
    dac_ctrl #(.CLK_DIV(1), .GAP_CYC(1)) u_fast (.clk_in(clk_in), .rst_n(rst_n), .bus(f_if));

    logic m_sync, m_sclk, m_din, m_done, m_ready;
    assign m_sync  = sel ? f_if.sync  : d_if.sync;
    assign m_sclk  = sel ? f_if.sclk  : d_if.sclk;
    assign m_din   = sel ? f_if.din   : d_if.din;
    assign m_done  = sel ? f_if.done  : d_if.done;
    assign m_ready = sel ? f_if.ready : d_if.ready;

    int tests = 0;
    int fails = 0;

    // Monitor: rebuilds each frame as the DAC would see it and records its timing.
    logic [15:0] fq[$];
    int          lowq[$], fallq[$], gapq[$], holdq[$], doneq[$];
    int          done_total = 0;

    initial begin
        logic        p_sync, p_sclk, in_hold;
        int          low_cnt, high_cnt, falls, hold_cnt;
        logic [15:0] shreg;
        p_sync = 1'b1; p_sclk = 1'b1; in_hold = 1'b0;
        low_cnt = 0; high_cnt = 0; falls = 0; hold_cnt = 0; shreg = '0;
        forever begin
            @(negedge clk_in);
            if (!rst_n) begin
                low_cnt = 0; falls = 0; shreg = '0; in_hold = 1'b0; high_cnt = 0;
            end else begin
                if (m_done) done_total++;
                if (!m_sync) begin
                    if (p_sync) begin
                        gapq.push_back(high_cnt);
                        low_cnt = 0;
                        falls = 0;
                    end
                    low_cnt++;
                    if (p_sclk && !m_sclk) begin
                        shreg = {shreg[14:0], m_din};
                        falls++;
                    end
                end else begin
                    if (!p_sync) begin
                        fq.push_back(shreg);
                        lowq.push_back(low_cnt);
                        fallq.push_back(falls);
                        doneq.push_back(int'(m_done));
                        high_cnt = 0;
                        in_hold = 1'b1;
                        hold_cnt = 0;
                    end
                    high_cnt++;
                    if (in_hold) begin
                        if (m_ready) begin
                            holdq.push_back(hold_cnt);
                            in_hold = 1'b0;
                        end else begin
                            hold_cnt++;
                        end
                    end
                end
            end
            p_sync = m_sync;
            p_sclk = m_sclk;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // which: 0 = sync, 1 = ready (of the selected instance)
    task automatic wait_for(input int which, input logic val, input string name);
        int k = 0;
        while (((which == 0) ? m_sync : m_ready) !== val && k < 2000) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= 2000) check({name, " timeout"}, 0, 1);
    endtask

    task automatic do_write(input logic [11:0] d, input logic [1:0] p);
        @(negedge clk_in);
        t_data = d;
        t_pd   = p;
        t_ctrl = 1'b1;
        @(negedge clk_in);
        t_ctrl = 1'b0;
    endtask

    typedef struct {
        logic        sel;
        logic [11:0] data;
        logic [1:0]  pd;
        logic [15:0] exp_frame;
        int          exp_low;
        int          exp_hold;
    } vec_t;

    vec_t vecs[5];

    task automatic back_to_back(input int exp_gap, input int exp_low);
        int n0, g0, d0;
        n0 = fq.size(); g0 = gapq.size(); d0 = done_total;
        @(negedge clk_in);
        t_data = 12'h001; t_pd = 2'b00; t_ctrl = 1'b1;
        wait_for(0, 1'b0, "b2b first start");
        t_data = 12'h002;
        wait_for(0, 1'b1, "b2b first end");
        wait_for(0, 1'b0, "b2b second start");
        t_ctrl = 1'b0;
        wait_for(1, 1'b1, "b2b ready");
        idle(5);
        check("b2b frame count", fq.size() - n0, 2);
        if (fq.size() >= n0 + 2) begin
            check("b2b frame0", int'(fq[n0]), 16'h0001);
            check("b2b frame1", int'(fq[n0 + 1]), 16'h0002);
            check("b2b low1", lowq[n0 + 1], exp_low);
        end
        if (gapq.size() >= g0 + 2) check("b2b sync high gap", gapq[g0 + 1], exp_gap);
        else check("b2b gap recorded", gapq.size() - g0, 2);
        check("b2b done pulses", done_total - d0, 2);
    endtask

    initial begin
        int n0, d0;
        vecs[0] = '{1'b0, 12'hA5C, 2'b00, 16'h0A5C, 64, 4};
        vecs[1] = '{1'b0, 12'hFFF, 2'b11, 16'h3FFF, 64, 4};
        vecs[2] = '{1'b0, 12'h000, 2'b01, 16'h1000, 64, 4};
        vecs[3] = '{1'b1, 12'hA5C, 2'b00, 16'h0A5C, 32, 1};
        vecs[4] = '{1'b1, 12'hFFF, 2'b10, 16'h2FFF, 32, 1};

        rst_n = 1'b0; sel = 1'b0; t_ctrl = 1'b0; t_data = '0; t_pd = '0;
        idle(3);
        check("reset ready", int'(d_if.ready), 1);
        check("reset busy", int'(d_if.busy), 0);
        check("reset sync", int'(d_if.sync), 1);
        check("reset sclk", int'(d_if.sclk), 1);
        check("reset din", int'(d_if.din), 0);
        check("reset done", int'(d_if.done), 0);
        check("reset fast sync", int'(f_if.sync), 1);
        check("reset fast ready", int'(f_if.ready), 1);
        rst_n = 1'b1;
        idle(3);
        check("idle without ctrl", int'(d_if.sync), 1);

        // Table-driven single writes on both dividers.
        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].sel;
            idle(2);
            n0 = fq.size(); d0 = done_total;
            do_write(vecs[i].data, vecs[i].pd);
            check($sformatf("v%0d sync low after accept", i), int'(m_sync), 0);
            wait_for(1, 1'b1, $sformatf("v%0d ready", i));
            idle(3);
            check($sformatf("v%0d frame count", i), fq.size() - n0, 1);
            if (fq.size() > n0) begin
                check($sformatf("v%0d frame", i), int'(fq[n0]), int'(vecs[i].exp_frame));
                check($sformatf("v%0d sync low cycles", i), lowq[n0], vecs[i].exp_low);
                check($sformatf("v%0d sclk falls", i), fallq[n0], 16);
                check($sformatf("v%0d done at sync rise", i), doneq[n0], 1);
                check($sformatf("v%0d hold cycles", i), holdq[n0], vecs[i].exp_hold);
            end
            check($sformatf("v%0d done pulses", i), done_total - d0, 1);
        end

        sel = 1'b0; idle(2);
        back_to_back(5, 64);
        sel = 1'b1; idle(2);
        back_to_back(2, 32);

        // Request and data change mid-frame must be ignored.
        sel = 1'b0; idle(2);
        n0 = fq.size(); d0 = done_total;
        do_write(12'h123, 2'b00);
        idle(20);
        t_ctrl = 1'b1; t_data = 12'h777;
        @(negedge clk_in);
        t_ctrl = 1'b0;
        wait_for(1, 1'b1, "ignore ready");
        idle(20);
        check("ignore frame count", fq.size() - n0, 1);
        if (fq.size() > n0) check("ignore frame", int'(fq[n0]), 16'h0123);
        check("ignore done pulses", done_total - d0, 1);
        check("ignore sync idle", int'(m_sync), 1);

        // Asynchronous reset during bit 7 (din high, sclk low).
        n0 = fq.size(); d0 = done_total;
        do_write(12'hFFF, 2'b00);
        idle(34);
        check("pre-reset sync", int'(d_if.sync), 0);
        check("pre-reset din", int'(d_if.din), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset sync", int'(d_if.sync), 1);
        check("async reset sclk", int'(d_if.sclk), 1);
        check("async reset din", int'(d_if.din), 0);
        check("async reset ready", int'(d_if.ready), 1);
        check("async reset busy", int'(d_if.busy), 0);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        check("aborted frame not completed", fq.size() - n0, 0);
        check("aborted done", done_total - d0, 0);
        n0 = fq.size();
        do_write(12'h456, 2'b00);
        wait_for(1, 1'b1, "post-reset ready");
        idle(3);
        check("post-reset frame count", fq.size() - n0, 1);
        if (fq.size() > n0) begin
            check("post-reset frame", int'(fq[n0]), 16'h0456);
            check("post-reset low", lowq[n0], 64);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end
endmodule
